// File: rtl/sysarr_pkg.sv
// Shared definitions for the systolic-array processing elements.
//   - default operand / partial-sum widths used by every PE flavour
//   - weight-buffer state encoding
//   - psum_limit(): largest / smallest value of a signed word of a given width,
//     used to build the saturation clamp constants
package sysarr_pkg;

    localparam int DEF_DATA_IN_BW     = 8;
    localparam int DEF_WEIGHT_BW      = 8;
    localparam int DEF_PARTIAL_SUM_BW = 19;

    typedef enum logic {
        WB_EMPTY  = 1'b0,
        WB_LOADED = 1'b1
    } wbuf_state_t;

    function automatic longint psum_limit(input int w, input bit want_max);
        longint one;
        one = 64'sd1;
        if (want_max) begin
            return (one << (w - 1)) - one;
        end
        return -(one << (w - 1));
    endfunction

endpackage

// File: rtl/pe_dbuf_if.sv
// Bundle of all per-PE data, weight-chain and control signals.
//   master : the array controller / neighbouring PEs (drives inputs)
//   slave  : the PE itself (drives DF_COL*, PSUM_OUT*, W_OUT, SHADOW_VLD, OVF)
interface pe_dbuf_if
    import sysarr_pkg::*;
#(
    parameter int DATA_IN_BW     = DEF_DATA_IN_BW,
    parameter int WEIGHT_BW      = DEF_WEIGHT_BW,
    parameter int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW
);
    logic signed [DATA_IN_BW-1:0]     DIN;
    logic                             DIN_VLD;
    logic signed [PARTIAL_SUM_BW-1:0] PSUM_IN;
    logic signed [WEIGHT_BW-1:0]      W_IN;
    logic                             w_shift;
    logic                             w_swap;
    logic                             ovf_clr;
    logic signed [DATA_IN_BW-1:0]     DF_COL;
    logic                             DF_COL_VLD;
    logic signed [PARTIAL_SUM_BW-1:0] PSUM_OUT;
    logic                             PSUM_OUT_VLD;
    logic signed [WEIGHT_BW-1:0]      W_OUT;
    logic                             SHADOW_VLD;
    logic                             OVF;

    modport master (
        output DIN, DIN_VLD, PSUM_IN, W_IN, w_shift, w_swap, ovf_clr,
        input  DF_COL, DF_COL_VLD, PSUM_OUT, PSUM_OUT_VLD, W_OUT, SHADOW_VLD, OVF
    );

    modport slave (
        input  DIN, DIN_VLD, PSUM_IN, W_IN, w_shift, w_swap, ovf_clr,
        output DF_COL, DF_COL_VLD, PSUM_OUT, PSUM_OUT_VLD, W_OUT, SHADOW_VLD, OVF
    );

endinterface

// File: rtl/dff.sv
// Resettable register with load enable.
//   clk, rstn : clock, asynchronous active-low reset (clears q)
//   en        : load d into q on the rising edge
//   d, q      : W-bit data in / out
module dff #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pe_wbuf.sv
// Double-buffered weight store for one PE.
//   clk, rstn  : clock, asynchronous active-low reset
//   w_shift    : load W_IN into the shadow register (column shift chain)
//   w_swap     : copy shadow into the active register if the shadow is loaded
//   W_IN/W_OUT : shift-chain input / shadow register output
//   weight     : active weight used by the multiplier
//   SHADOW_VLD : shadow holds a weight that has not yet been swapped in
module pe_wbuf
    import sysarr_pkg::*;
#(
    parameter int WEIGHT_BW = DEF_WEIGHT_BW
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        w_shift,
    input  logic                        w_swap,
    input  logic signed [WEIGHT_BW-1:0] W_IN,
    output logic signed [WEIGHT_BW-1:0] W_OUT,
    output logic signed [WEIGHT_BW-1:0] weight,
    output logic                        SHADOW_VLD
);

    wbuf_state_t                 state_q, state_d;
    logic signed [WEIGHT_BW-1:0] shadow_q;
    logic signed [WEIGHT_BW-1:0] weight_q;
    logic                        shadow_ld;
    logic                        active_ld;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= WB_EMPTY;
            shadow_q <= '0;
            weight_q <= '0;
        end else begin
            state_q <= state_d;
            if (shadow_ld) shadow_q <= W_IN;
            // Active takes the pre-edge shadow, so shift+swap moves the old
            // shadow forward while the new W_IN lands behind it.
            if (active_ld) weight_q <= shadow_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        shadow_ld = 1'b0;
        active_ld = 1'b0;
        case (state_q)
            WB_EMPTY: begin
                // A swap with nothing loaded is ignored.
                if (w_shift) begin
                    shadow_ld = 1'b1;
                    state_d   = WB_LOADED;
                end
            end
            WB_LOADED: begin
                if (w_swap) begin
                    active_ld = 1'b1;
                end
                if (w_shift) begin
                    shadow_ld = 1'b1;
                end else if (w_swap) begin
                    state_d = WB_EMPTY;
                end
            end
            default: state_d = WB_EMPTY;
        endcase
    end

    assign W_OUT      = shadow_q;
    assign weight     = weight_q;
    assign SHADOW_VLD = (state_q == WB_LOADED);

endmodule

// File: rtl/pe_dbuf.sv
// Weight-stationary PE with double-buffered weight, valid-tagged data and
// partial sums, optional saturating accumulation and sticky overflow flag.
//   clk, rstn : clock, asynchronous active-low reset (clears every register)
//   bus       : pe_dbuf_if slave port
//     DIN/DIN_VLD, PSUM_IN     -> DF_COL/DF_COL_VLD, PSUM_OUT/PSUM_OUT_VLD (1 cycle)
//     W_IN, w_shift, w_swap    -> W_OUT, SHADOW_VLD (weight chain)
//     ovf_clr                  -> OVF (sticky, a new overflow beats the clear)
module pe_dbuf
    import sysarr_pkg::*;
#(
    parameter int DATA_IN_BW     = DEF_DATA_IN_BW,
    parameter int WEIGHT_BW      = DEF_WEIGHT_BW,
    parameter int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
    parameter bit SATURATE       = 1'b0
) (
    input  logic    clk,
    input  logic    rstn,
    pe_dbuf_if.slave bus
);

    localparam int PROD_BW = DATA_IN_BW + WEIGHT_BW;
    localparam int EXT_BW  = PARTIAL_SUM_BW + 1;
    localparam logic signed [PARTIAL_SUM_BW-1:0] PSUM_MAX =
        PARTIAL_SUM_BW'(psum_limit(PARTIAL_SUM_BW, 1'b1));
    localparam logic signed [PARTIAL_SUM_BW-1:0] PSUM_MIN =
        PARTIAL_SUM_BW'(psum_limit(PARTIAL_SUM_BW, 1'b0));

    // One guard bit above the partial-sum width: overflow shows up as the top
    // two bits disagreeing. Clamp in saturating builds, otherwise drop the guard.
    function automatic logic signed [PARTIAL_SUM_BW-1:0] fit_psum(
        input logic signed [EXT_BW-1:0] s
    );
        if (SATURATE && (s[EXT_BW-1] != s[EXT_BW-2])) begin
            return s[EXT_BW-1] ? PSUM_MIN : PSUM_MAX;
        end
        return s[PARTIAL_SUM_BW-1:0];
    endfunction

    logic signed [WEIGHT_BW-1:0]      weight;
    logic signed [WEIGHT_BW-1:0]      w_out;
    logic                             shadow_vld;

    pe_wbuf #(
        .WEIGHT_BW(WEIGHT_BW)
    ) u_wbuf (
        .clk       (clk),
        .rstn      (rstn),
        .w_shift   (bus.w_shift),
        .w_swap    (bus.w_swap),
        .W_IN      (bus.W_IN),
        .W_OUT     (w_out),
        .weight    (weight),
        .SHADOW_VLD(shadow_vld)
    );

    // Stage p0: multiply-accumulate on the operands sampled at this edge
    logic signed [PROD_BW-1:0]        prod_p0;
    logic signed [EXT_BW-1:0]         sum_p0;
    logic signed [PARTIAL_SUM_BW-1:0] psum_p0;
    logic                             ovf_p0;

    assign prod_p0 = PROD_BW'(bus.DIN) * PROD_BW'(weight);
    assign sum_p0  = EXT_BW'(bus.PSUM_IN) + EXT_BW'(prod_p0);
    assign ovf_p0  = sum_p0[EXT_BW-1] ^ sum_p0[EXT_BW-2];
    assign psum_p0 = fit_psum(sum_p0);

    // Stage p1: registered outputs; data holds on invalid beats
    logic [DATA_IN_BW-1:0]     df_col_p1;
    logic [PARTIAL_SUM_BW-1:0] psum_p1;
    logic                      vld_p1;
    logic                      ovf_q;

    dff #(.W(DATA_IN_BW)) u_df_col (
        .clk (clk),
        .rstn(rstn),
        .en  (bus.DIN_VLD),
        .d   (bus.DIN),
        .q   (df_col_p1)
    );

    dff #(.W(PARTIAL_SUM_BW)) u_psum (
        .clk (clk),
        .rstn(rstn),
        .en  (bus.DIN_VLD),
        .d   (psum_p0),
        .q   (psum_p1)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1 <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            vld_p1 <= bus.DIN_VLD;
            if (bus.DIN_VLD && ovf_p0) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.DF_COL       = df_col_p1;
    assign bus.DF_COL_VLD   = vld_p1;
    assign bus.PSUM_OUT     = psum_p1;
    assign bus.PSUM_OUT_VLD = vld_p1;
    assign bus.W_OUT        = w_out;
    assign bus.SHADOW_VLD   = shadow_vld;
    assign bus.OVF          = ovf_q;

endmodule

// File: tb/tb_pe_dbuf.sv
// Bench for pe_dbuf: a saturating and a wrapping instance share one stimulus
// stream and are compared every cycle against an arithmetic reference model.
module tb_pe_dbuf;

    localparam longint PMAX = 262143;
    localparam longint PMIN = -262144;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic signed [7:0]  din;
    logic               din_vld;
    logic signed [18:0] psum_in;
    logic signed [7:0]  w_in;
    logic               w_shift;
    logic               w_swap;
    logic               ovf_clr;

    pe_dbuf_if #(.DATA_IN_BW(8), .WEIGHT_BW(8), .PARTIAL_SUM_BW(19)) bus_s ();
    pe_dbuf_if #(.DATA_IN_BW(8), .WEIGHT_BW(8), .PARTIAL_SUM_BW(19)) bus_w ();

    assign bus_s.DIN = din;     assign bus_w.DIN = din;
    assign bus_s.DIN_VLD = din_vld; assign bus_w.DIN_VLD = din_vld;
    assign bus_s.PSUM_IN = psum_in; assign bus_w.PSUM_IN = psum_in;
    assign bus_s.W_IN = w_in;   assign bus_w.W_IN = w_in;
    assign bus_s.w_shift = w_shift; assign bus_w.w_shift = w_shift;
    assign bus_s.w_swap = w_swap;   assign bus_w.w_swap = w_swap;
    assign bus_s.ovf_clr = ovf_clr; assign bus_w.ovf_clr = ovf_clr;

    pe_dbuf #(.DATA_IN_BW(8), .WEIGHT_BW(8), .PARTIAL_SUM_BW(19), .SATURATE(1'b1)) u_sat (
        .clk (clk),
        .rstn(rstn),
        .bus (bus_s)
    );

    pe_dbuf #(.DATA_IN_BW(8), .WEIGHT_BW(8), .PARTIAL_SUM_BW(19), .SATURATE(1'b0)) u_wrap (
        .clk (clk),
        .rstn(rstn),
        .bus (bus_w)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state: plain integers, index 0 = saturating, 1 = wrapping.
    longint m_active, m_shadow, m_loaded, m_df, m_vld, m_ovf;
    longint m_psum [2];

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_shadow = 0; m_loaded = 0;
        m_df = 0; m_vld = 0; m_ovf = 0;
        m_psum[0] = 0; m_psum[1] = 0;
    endtask

    task automatic model_step();
        longint s, t;
        bit over;
        over = 1'b0;
        if (din_vld) begin
            s = longint'(psum_in) + longint'(din) * m_active;
            over = (s > PMAX) || (s < PMIN);
            m_psum[0] = (s > PMAX) ? PMAX : ((s < PMIN) ? PMIN : s);
            t = s & 64'h7FFFF;
            if (t > PMAX) t = t - 64'h80000;
            m_psum[1] = t;
            m_df = longint'(din);
        end
        if (over) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
        m_vld = din_vld ? 1 : 0;
        if (m_loaded != 0 && w_swap) m_active = m_shadow;
        if (w_shift) begin
            m_shadow = longint'(w_in);
            m_loaded = 1;
        end else if (w_swap) begin
            m_loaded = 0;
        end
    endtask

    task automatic check_all();
        check("sat.DF_COL",       64'(bus_s.DF_COL),       m_df);
        check("sat.DF_COL_VLD",   64'(bus_s.DF_COL_VLD),   m_vld);
        check("sat.PSUM_OUT",     64'(bus_s.PSUM_OUT),     m_psum[0]);
        check("sat.PSUM_OUT_VLD", 64'(bus_s.PSUM_OUT_VLD), m_vld);
        check("sat.W_OUT",        64'(bus_s.W_OUT),        m_shadow);
        check("sat.SHADOW_VLD",   64'(bus_s.SHADOW_VLD),   m_loaded);
        check("sat.OVF",          64'(bus_s.OVF),          m_ovf);
        check("wrap.DF_COL",      64'(bus_w.DF_COL),       m_df);
        check("wrap.PSUM_OUT",    64'(bus_w.PSUM_OUT),     m_psum[1]);
        check("wrap.PSUM_OUT_VLD", 64'(bus_w.PSUM_OUT_VLD), m_vld);
        check("wrap.W_OUT",       64'(bus_w.W_OUT),        m_shadow);
        check("wrap.SHADOW_VLD",  64'(bus_w.SHADOW_VLD),   m_loaded);
        check("wrap.OVF",         64'(bus_w.OVF),          m_ovf);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic vld, input logic signed [7:0] d,
                         input logic signed [18:0] p, input logic sh,
                         input logic sw, input logic signed [7:0] wi,
                         input logic clr);
        din_vld = vld; din = d; psum_in = p;
        w_shift = sh; w_swap = sw; w_in = wi; ovf_clr = clr;
        cycle();
    endtask

    // Entered just after a rising edge: reset is asserted mid-cycle and checked
    // before any further edge, then released away from the edge.
    task automatic do_reset();
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check("rst.PSUM_OUT",   64'(bus_s.PSUM_OUT), 0);
        check("rst.DF_COL",     64'(bus_s.DF_COL), 0);
        check("rst.W_OUT",      64'(bus_w.W_OUT), 0);
        check("rst.SHADOW_VLD", 64'(bus_s.SHADOW_VLD), 0);
        check("rst.OVF",        64'(bus_w.OVF), 0);
        check_all();
        din_vld = 1'b0; w_shift = 1'b0; w_swap = 1'b0; ovf_clr = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        #2 rstn = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        din = '0; din_vld = 1'b0; psum_in = '0; w_in = '0;
        w_shift = 1'b0; w_swap = 1'b0; ovf_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #4 rstn = 1'b1;

        // Idle beats with junk on the data inputs must not move the outputs.
        for (int i = 0; i < 3; i++) begin
            r = $urandom;
            drive(1'b0, r[7:0], r[26:8], 1'b0, 1'b0, 8'sd0, 1'b0);
            check("idle.PSUM_OUT", 64'(bus_s.PSUM_OUT), 0);
        end

        // Load -3, swap, compute 100 + 7*(-3).
        drive(1'b0, 8'sd0, 19'sd0, 1'b1, 1'b0, -8'sd3, 1'b0);
        check("load.SHADOW_VLD1", 64'(bus_s.SHADOW_VLD), 1);
        drive(1'b0, 8'sd0, 19'sd0, 1'b0, 1'b1, 8'sd0, 1'b0);
        check("load.SHADOW_VLD0", 64'(bus_s.SHADOW_VLD), 0);
        drive(1'b1, 8'sd7, 19'sd100, 1'b0, 1'b0, 8'sd0, 1'b0);
        check("mac.PSUM_OUT",  64'(bus_s.PSUM_OUT), 79);
        check("mac.DF_COL",    64'(bus_w.DF_COL), 7);
        check("mac.PSUM_VLD",  64'(bus_s.PSUM_OUT_VLD), 1);

        // Asynchronous reset with non-zero outputs present.
        do_reset();

        // active=2, shadow=5, then shift+swap with W_IN=9.
        drive(1'b0, 8'sd0, 19'sd0, 1'b1, 1'b0, 8'sd2, 1'b0);
        drive(1'b0, 8'sd0, 19'sd0, 1'b0, 1'b1, 8'sd0, 1'b0);
        drive(1'b0, 8'sd0, 19'sd0, 1'b1, 1'b0, 8'sd5, 1'b0);
        drive(1'b0, 8'sd0, 19'sd0, 1'b1, 1'b1, 8'sd9, 1'b0);
        check("ss.W_OUT",      64'(bus_s.W_OUT), 9);
        check("ss.SHADOW_VLD", 64'(bus_s.SHADOW_VLD), 1);
        drive(1'b1, 8'sd1, 19'sd0, 1'b0, 1'b0, 8'sd0, 1'b0);
        check("ss.active5",    64'(bus_s.PSUM_OUT), 5);
        drive(1'b0, 8'sd0, 19'sd0, 1'b0, 1'b1, 8'sd0, 1'b0);
        drive(1'b0, 8'sd0, 19'sd0, 1'b0, 1'b1, 8'sd0, 1'b0);
        drive(1'b1, 8'sd1, 19'sd0, 1'b0, 1'b0, 8'sd0, 1'b0);
        check("ss.empty_swap", 64'(bus_s.PSUM_OUT), 9);

        // Saturation corners with W=127.
        drive(1'b0, 8'sd0, 19'sd0, 1'b1, 1'b0, 8'sd127, 1'b0);
        drive(1'b0, 8'sd0, 19'sd0, 1'b0, 1'b1, 8'sd0, 1'b0);
        drive(1'b1, 8'sd127, 19'sd262143, 1'b0, 1'b0, 8'sd0, 1'b0);
        check("sat.pos_clamp", 64'(bus_s.PSUM_OUT), 262143);
        check("sat.ovf_set",   64'(bus_s.OVF), 1);
        drive(1'b1, -8'sd128, -19'sd262144, 1'b0, 1'b0, 8'sd0, 1'b0);
        check("sat.neg_clamp", 64'(bus_s.PSUM_OUT), -262144);
        drive(1'b1, 8'sd127, 19'sd262143, 1'b0, 1'b0, 8'sd0, 1'b1);
        check("sat.set_wins",  64'(bus_s.OVF), 1);
        drive(1'b0, 8'sd0, 19'sd0, 1'b0, 1'b0, 8'sd0, 1'b1);
        check("sat.ovf_clr",   64'(bus_s.OVF), 0);

        // Wrap: 262143 + 1*1.
        drive(1'b0, 8'sd0, 19'sd0, 1'b1, 1'b0, 8'sd1, 1'b0);
        drive(1'b0, 8'sd0, 19'sd0, 1'b0, 1'b1, 8'sd0, 1'b0);
        drive(1'b1, 8'sd1, 19'sd262143, 1'b0, 1'b0, 8'sd0, 1'b0);
        check("wrap.value",    64'(bus_w.PSUM_OUT), -262144);
        check("wrap.ovf",      64'(bus_w.OVF), 1);

        // Valid gaps.
        for (int i = 0; i < 8; i++) begin
            drive((i % 2) == 0, 8'sd4, 19'(i * 10), 1'b0, 1'b0, 8'sd0, 1'b0);
            check("gap.PSUM_OUT_VLD", 64'(bus_s.PSUM_OUT_VLD), ((i % 2) == 0) ? 1 : 0);
        end

        // Random traffic, with occasional asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom;
            din     = r[7:0];
            w_in    = r[15:8];
            din_vld = r[16];
            w_shift = (r[18:17] == 2'b00);
            w_swap  = (r[21:19] < 3'd2);
            ovf_clr = (r[24:22] == 3'b000);
            r = $urandom;
            if (r[1:0] == 2'b00) begin
                psum_in = r[2] ? 19'(PMAX - longint'(r[12:3]))
                               : 19'(PMIN + longint'(r[12:3]));
            end else begin
                psum_in = r[31:13];
            end
            cycle();
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pe_dbuf.md
# pe_dbuf

Second-generation weight-stationary processing element for the systolic array. It keeps the multiply-accumulate datapath of the current PE and adds four things: a double-buffered weight (shadow register loaded through a per-column shift chain, then swapped into the active register), valid-tagged data and partial sums, optional saturating accumulation, and a sticky overflow flag. Instances tile the array exactly as today: data flows down columns, partial sums flow right.

## Interface
- DATA_IN_BW, 8, signed activation width
- WEIGHT_BW, 8, signed weight width
- PARTIAL_SUM_BW, 19, signed partial-sum width
- SATURATE, 0, 1 = clamp sums to PARTIAL_SUM_BW range; 0 = two's-complement wrap
- clk  in  1  single clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- DIN  in  DATA_IN_BW  signed activation
- DIN_VLD  in  1  DIN qualifier
- PSUM_IN  in  PARTIAL_SUM_BW  signed partial sum from the left
- W_IN  in  WEIGHT_BW  weight shift-chain input
- w_shift  in  1  load W_IN into the shadow register (column-wide)
- w_swap  in  1  copy the shadow register into the active register (array-wide)
- ovf_clr  in  1  clear OVF
- DF_COL  out  DATA_IN_BW  registered DIN, to the PE below
- DF_COL_VLD  out  1  registered DIN_VLD
- PSUM_OUT  out  PARTIAL_SUM_BW  registered partial sum, to the right
- PSUM_OUT_VLD  out  1  registered DIN_VLD
- W_OUT  out  WEIGHT_BW  shadow register, to the next PE in the chain
- SHADOW_VLD  out  1  shadow register holds an unswapped weight
- OVF  out  1  sticky overflow / saturation flag

## Operation
- Product: DIN × active_weight, full width DATA_IN_BW+WEIGHT_BW, signed.
- Sum:
  - Computed at PARTIAL_SUM_BW+1 bits: sign-extended PSUM_IN plus sign-extended product.
  - Overflow condition: the top two bits of that sum differ.
  - SATURATE=1: on overflow, clamp to +(2^(PSUM_BW−1))−1 or −2^(PSUM_BW−1).
  - SATURATE=0: truncate to PARTIAL_SUM_BW bits.
- Valid handling:
  - DIN_VLD=1: DF_COL ← DIN; PSUM_OUT ← sum.
  - DIN_VLD=0: DF_COL and PSUM_OUT hold their values.
  - DF_COL_VLD and PSUM_OUT_VLD ← DIN_VLD every cycle.
- OVF:
  - Set when DIN_VLD=1 and the overflow condition holds, in either SATURATE mode.
  - Cleared by ovf_clr.
  - If set and clear occur in the same cycle, set wins.
- Weight buffer (two-state FSM on SHADOW_VLD):
  - EMPTY: w_shift → shadow ← W_IN, go to LOADED. w_swap alone is ignored; the active weight is unchanged.
  - LOADED, w_swap only: active ← shadow, go to EMPTY.
  - LOADED, w_shift only: shadow ← W_IN, stay LOADED. This is the chain shift.
  - LOADED, w_shift and w_swap together: active ← old shadow, shadow ← W_IN, stay LOADED.
  - EMPTY, w_shift and w_swap together: shadow ← W_IN, go to LOADED; active is unchanged.
- Loading a column: an N-deep column is loaded by N consecutive w_shift cycles, bottom weight first.

## Timing
- Reset (rstn low, asynchronous): all registers and outputs go to 0.
  - Includes: DF_COL, DF_COL_VLD, PSUM_OUT, PSUM_OUT_VLD, W_OUT, active weight, SHADOW_VLD, OVF.
- Latency:
  - DIN and PSUM_IN → DF_COL and PSUM_OUT: 1 cycle.
  - W_IN → W_OUT: 1 cycle.
  - w_swap → new active weight: takes effect at the edge where w_swap is sampled. A product registered at that edge still uses the old weight; the first DIN_VLD beat sampled at the next edge uses the new weight.
- Operand alignment: PSUM_IN and DIN are sampled on the same edge. The array skews inputs externally, as today.
- No back-pressure; the valid bits are the only qualifier.
- Reset mid-load: shadow contents are lost and SHADOW_VLD=0; the controller must restart the column shift.

## Structure
- Shared package sysarr_pkg:
  - default DATA_IN_BW, WEIGHT_BW and PARTIAL_SUM_BW
  - a function returning PSUM max/min for a given width, used by the saturation logic
- Sub-module pe_wbuf: shadow register, active register and SHADOW_VLD FSM.
  - Ports: clk, rstn, w_shift, w_swap, W_IN, W_OUT, weight, SHADOW_VLD.
- Top level: datapath, valid pipeline and OVF. Existing dff instances are reused for DF_COL and PSUM_OUT, with enable added.

## Test plan
- Reset state: assert rstn=0 mid-stream → all outputs 0 immediately, with no clock edge needed. Release reset, DIN_VLD=0 → PSUM_OUT and DF_COL stay 0.
- Load and compute: w_shift with W_IN=−3, then w_swap → SHADOW_VLD goes 1 then 0. Next cycle DIN=7, PSUM_IN=100, DIN_VLD=1 → one cycle later PSUM_OUT=79, PSUM_OUT_VLD=1, DF_COL=7.
- Simultaneous shift+swap: shadow=5, active=2; assert both with W_IN=9 → active=5, W_OUT=9, SHADOW_VLD=1. An empty swap afterwards (after a separate swap has emptied the shadow) leaves active unchanged.
- Saturation, SATURATE=1, widths 8/8/19:
  - PSUM_IN=262143, DIN=127, W=127 → PSUM_OUT=262143, OVF=1.
  - PSUM_IN=−262144, DIN=−128, W=127 → PSUM_OUT=−262144.
  - ovf_clr asserted together with a new overflow → OVF stays 1.
- Wrap, SATURATE=0: PSUM_IN=262143, DIN=1, W=1 → PSUM_OUT=−262144, OVF=1.
- Valid gaps: alternate DIN_VLD=1/0 with DIN=4, 4, … → PSUM_OUT holds on invalid beats, and PSUM_OUT_VLD toggles 1/0 one cycle behind DIN_VLD.
